// File: rtl/pio_bank_if.sv
// rtl/pio_bank_if.sv - Avalon-MM slave bus bundle for pio_bank
//
// Ports (signals):
//   avs_address        word address, channel = [MSB:2], register = [1:0]
//   avs_read           read strobe
//   avs_write          write strobe
//   avs_writedata      write data
//   avs_byteenable     byte lanes for writes
//   avs_readdata       registered read data
//   avs_readdatavalid  one-cycle read data qualifier
// Modports: master drives the command side, slave drives the response side.

interface pio_bank_if #(
  parameter int NUM_CH = 4
) ();

  localparam int ADDR_W = $clog2(NUM_CH) + 2;

  logic [ADDR_W-1:0] avs_address;
  logic              avs_read;
  logic              avs_write;
  logic [31:0]       avs_writedata;
  logic [3:0]        avs_byteenable;
  logic [31:0]       avs_readdata;
  logic              avs_readdatavalid;

  modport master (
    output avs_address,
    output avs_read,
    output avs_write,
    output avs_writedata,
    output avs_byteenable,
    input  avs_readdata,
    input  avs_readdatavalid
  );

  modport slave (
    input  avs_address,
    input  avs_read,
    input  avs_write,
    input  avs_writedata,
    input  avs_byteenable,
    output avs_readdata,
    output avs_readdatavalid
  );

endinterface

// File: rtl/pio_bank.sv
// rtl/pio_bank.sv - multi-channel parallel I/O bank with edge capture and interrupt
//
// Ports:
//   clk      system clock
//   reset    synchronous reset, active-high
//   avs      Avalon-MM slave (pio_bank_if.slave), 1-cycle fixed read latency, no waitrequest
//   pio_in   external inputs, channel c at [c*WIDTH +: WIDTH], asynchronous to clk
//   pio_out  registered outputs, same packing
//   irq      registered level interrupt: OR over channels of (EDGE_CAP & IRQ_MASK)
// Per-channel registers: 0 DATA_IN (RO), 1 DATA_OUT, 2 IRQ_MASK, 3 EDGE_CAP (W1C).
// Optional macro PIO_BANK_DEBOUNCE_EN inserts a per-channel stability filter
// between the synchroniser and DATA_IN / edge detection.

module pio_bank #(
  parameter int          NUM_CH          = 4,
  parameter int          WIDTH           = 32,
  parameter int          EDGE_MODE       = 0,
  parameter logic [31:0] OUT_RESET       = 32'h0,
  parameter int          DEBOUNCE_CYCLES = 16
) (
  input  logic                    clk,
  input  logic                    reset,
  pio_bank_if.slave               avs,
  input  logic [NUM_CH*WIDTH-1:0] pio_in,
  output logic [NUM_CH*WIDTH-1:0] pio_out,
  output logic                    irq
);

  localparam int ADDR_W = $clog2(NUM_CH) + 2;
  localparam int CW     = NUM_CH * WIDTH;

  if (NUM_CH < 1 || NUM_CH > 16 || WIDTH < 1 || WIDTH > 32 ||
      EDGE_MODE < 0 || EDGE_MODE > 2 || DEBOUNCE_CYCLES < 1) begin : g_bad_param
    $error("pio_bank: parameter out of range");
  end

  // ---------------------------------------------------------------------------
  // Input path: 2-flop synchroniser, optional filter, edge detector
  // ---------------------------------------------------------------------------
  logic [CW-1:0] sync1_q;
  logic [CW-1:0] sync2_q;
  logic [CW-1:0] filt;
  logic [CW-1:0] prev_q;
  logic [CW-1:0] edge_hit;

  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_q <= '0;
      sync2_q <= '0;
      prev_q  <= '0;
    end else begin
      sync1_q <= pio_in;
      sync2_q <= sync1_q;
      prev_q  <= filt;
    end
  end

`ifdef PIO_BANK_DEBOUNCE_EN
  localparam int              CNT_W   = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES);

  // sync3_q is the previous-cycle synchronised value; any difference in a
  // channel restarts that channel's stability count.
  logic [CW-1:0]    sync3_q;
  logic [CW-1:0]    filt_q;
  logic [CNT_W-1:0] cnt_q    [NUM_CH];
  logic [CNT_W-1:0] cnt_next [NUM_CH];

  always_comb begin
    for (int c = 0; c < NUM_CH; c++) begin
      cnt_next[c] = '0;
      if (sync2_q[c*WIDTH +: WIDTH] != sync3_q[c*WIDTH +: WIDTH]) begin
        cnt_next[c] = '0;
      end else if (cnt_q[c] == CNT_MAX) begin
        cnt_next[c] = CNT_MAX;
      end else begin
        cnt_next[c] = cnt_q[c] + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sync3_q <= '0;
      filt_q  <= '0;
      for (int c = 0; c < NUM_CH; c++) begin
        cnt_q[c] <= '0;
      end
    end else begin
      sync3_q <= sync2_q;
      for (int c = 0; c < NUM_CH; c++) begin
        cnt_q[c] <= cnt_next[c];
        // A count of CNT_MAX implies the value has not moved, so reloading
        // while saturated is harmless.
        if (cnt_next[c] == CNT_MAX) begin
          filt_q[c*WIDTH +: WIDTH] <= sync2_q[c*WIDTH +: WIDTH];
        end
      end
    end
  end

  assign filt = filt_q;
`else
  assign filt = sync2_q;
`endif

  always_comb begin
    case (EDGE_MODE)
      0:       edge_hit = filt & ~prev_q;
      1:       edge_hit = ~filt & prev_q;
      default: edge_hit = filt ^ prev_q;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Address decode and write data lanes
  // ---------------------------------------------------------------------------
  logic [ADDR_W-1:0] ch_idx;
  logic [1:0]        reg_sel;
  logic [NUM_CH-1:0] ch_sel;
  logic [31:0]       be_bits;
  logic [WIDTH-1:0]  wmask;
  logic [WIDTH-1:0]  wdata;

  assign reg_sel = avs.avs_address[1:0];
  assign ch_idx  = ADDR_W'(avs.avs_address >> 2);
  assign be_bits = {{8{avs.avs_byteenable[3]}}, {8{avs.avs_byteenable[2]}},
                    {8{avs.avs_byteenable[1]}}, {8{avs.avs_byteenable[0]}}};
  assign wmask   = be_bits[WIDTH-1:0];
  assign wdata   = avs.avs_writedata[WIDTH-1:0];

  // Out-of-range channel indices select nothing: reads return 0, writes drop.
  always_comb begin
    for (int c = 0; c < NUM_CH; c++) begin
      ch_sel[c] = (int'(ch_idx) == c);
    end
  end

  // ---------------------------------------------------------------------------
  // Channel registers
  // ---------------------------------------------------------------------------
  logic [WIDTH-1:0] out_q   [NUM_CH];
  logic [WIDTH-1:0] mask_q  [NUM_CH];
  logic [WIDTH-1:0] cap_q   [NUM_CH];
  logic [WIDTH-1:0] cap_clr [NUM_CH];

  always_comb begin
    for (int c = 0; c < NUM_CH; c++) begin
      cap_clr[c] = '0;
      if (avs.avs_write && ch_sel[c] && reg_sel == 2'd3) begin
        cap_clr[c] = wdata & wmask;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int c = 0; c < NUM_CH; c++) begin
        out_q[c]  <= OUT_RESET[WIDTH-1:0];
        mask_q[c] <= '0;
        cap_q[c]  <= '0;
      end
    end else begin
      for (int c = 0; c < NUM_CH; c++) begin
        if (avs.avs_write && ch_sel[c] && reg_sel == 2'd1) begin
          out_q[c] <= (out_q[c] & ~wmask) | (wdata & wmask);
        end
        if (avs.avs_write && ch_sel[c] && reg_sel == 2'd2) begin
          mask_q[c] <= (mask_q[c] & ~wmask) | (wdata & wmask);
        end
        // OR-ing the new edge after the clear makes a same-cycle edge win.
        cap_q[c] <= (cap_q[c] & ~cap_clr[c]) | edge_hit[c*WIDTH +: WIDTH];
      end
    end
  end

  for (genvar g = 0; g < NUM_CH; g++) begin : g_out
    assign pio_out[g*WIDTH +: WIDTH] = out_q[g];
  end

  // ---------------------------------------------------------------------------
  // Read path and interrupt
  // ---------------------------------------------------------------------------
  logic [31:0] rd_mux;
  logic        irq_any;

  // Sampled from current register state, so a same-cycle write is not seen.
  always_comb begin
    rd_mux = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      if (ch_sel[c]) begin
        case (reg_sel)
          2'd0:    rd_mux = 32'(filt[c*WIDTH +: WIDTH]);
          2'd1:    rd_mux = 32'(out_q[c]);
          2'd2:    rd_mux = 32'(mask_q[c]);
          default: rd_mux = 32'(cap_q[c]);
        endcase
      end
    end
  end

  always_comb begin
    irq_any = 1'b0;
    for (int c = 0; c < NUM_CH; c++) begin
      irq_any = irq_any | (|(cap_q[c] & mask_q[c]));
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      avs.avs_readdata      <= '0;
      avs.avs_readdatavalid <= 1'b0;
      irq                   <= 1'b0;
    end else begin
      avs.avs_readdatavalid <= avs.avs_read;
      if (avs.avs_read) begin
        avs.avs_readdata <= rd_mux;
      end
      irq <= irq_any;
    end
  end

endmodule

// File: tb/tb_pio_bank.sv
// tb/tb_pio_bank.sv - directed self-checking bench for pio_bank

module tb_pio_bank;

  logic         clk = 1'b0;
  logic         reset;
  logic [127:0] pio_in4;
  logic [127:0] pio_out4;
  logic         irq4;
  logic [95:0]  pio_in3;
  logic [95:0]  pio_out3;
  logic         irq3;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  pio_bank_if #(.NUM_CH(4)) bus4 ();
  pio_bank_if #(.NUM_CH(3)) bus3 ();

  pio_bank #(
    .NUM_CH(4), .WIDTH(32), .EDGE_MODE(0),
    .OUT_RESET(32'h0000_00A5), .DEBOUNCE_CYCLES(16)
  ) u_dut4 (
    .clk(clk), .reset(reset), .avs(bus4.slave),
    .pio_in(pio_in4), .pio_out(pio_out4), .irq(irq4)
  );

  pio_bank #(
    .NUM_CH(3), .WIDTH(32), .EDGE_MODE(0),
    .OUT_RESET(32'h0), .DEBOUNCE_CYCLES(16)
  ) u_dut3 (
    .clk(clk), .reset(reset), .avs(bus3.slave),
    .pio_in(pio_in3), .pio_out(pio_out3), .irq(irq3)
  );

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Bus helpers start and return just after a falling edge.
  task automatic wr4(input logic [3:0] a, input logic [31:0] d, input logic [3:0] be);
    bus4.avs_address = a; bus4.avs_writedata = d; bus4.avs_byteenable = be;
    bus4.avs_write = 1'b1;
    @(negedge clk);
    bus4.avs_write = 1'b0;
  endtask

  task automatic rd4(input logic [3:0] a, output logic [31:0] d, output logic v);
    bus4.avs_address = a; bus4.avs_read = 1'b1;
    @(negedge clk);
    bus4.avs_read = 1'b0;
    d = bus4.avs_readdata; v = bus4.avs_readdatavalid;
  endtask

  task automatic wr3(input logic [3:0] a, input logic [31:0] d, input logic [3:0] be);
    bus3.avs_address = a; bus3.avs_writedata = d; bus3.avs_byteenable = be;
    bus3.avs_write = 1'b1;
    @(negedge clk);
    bus3.avs_write = 1'b0;
  endtask

  task automatic rd3(input logic [3:0] a, output logic [31:0] d, output logic v);
    bus3.avs_address = a; bus3.avs_read = 1'b1;
    @(negedge clk);
    bus3.avs_read = 1'b0;
    d = bus3.avs_readdata; v = bus3.avs_readdatavalid;
  endtask

  task automatic test_reset();
    logic [31:0] d; logic v; logic [3:0] a;
    reset = 1'b1; pio_in4 = '0; pio_in3 = '0;
    bus4.avs_address = 4'd9; bus4.avs_read = 1'b1;
    repeat (3) @(negedge clk);
    bus4.avs_read = 1'b0; reset = 1'b0;
    @(negedge clk);
    n_cmp++; if (bus4.avs_readdatavalid !== 1'b0) begin n_err++; $display("FAIL reset_rdv: got %b want 0", bus4.avs_readdatavalid); end
    n_cmp++; if (bus4.avs_readdata !== 32'h0) begin n_err++; $display("FAIL reset_rdata: got %h want 0", bus4.avs_readdata); end
    n_cmp++; if (irq4 !== 1'b0) begin n_err++; $display("FAIL reset_irq: got %b want 0", irq4); end
    for (int c = 0; c < 4; c++) begin
      n_cmp++; if (pio_out4[c*32 +: 32] !== 32'h0000_00A5) begin n_err++; $display("FAIL reset_pio_out ch%0d: got %h want 000000a5", c, pio_out4[c*32 +: 32]); end
    end
    n_cmp++; if (pio_out3 !== 96'h0) begin n_err++; $display("FAIL reset_pio_out3: got %h want 0", pio_out3); end
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        if (r != 1) begin
          a = 4'(c * 4 + r);
          rd4(a, d, v);
          n_cmp++; if (v !== 1'b1 || d !== 32'h0) begin n_err++; $display("FAIL reset_read addr %0d: got v=%b d=%h want v=1 d=0", a, v, d); end
        end
      end
    end
  endtask

  task automatic test_byte_write();
    logic [31:0] d; logic v;
    wr4(4'd9, 32'hDEAD_BEEF, 4'b0101);
    n_cmp++; if (pio_out4[64 +: 32] !== 32'h00AD_00EF) begin n_err++; $display("FAIL be_pio_out ch2: got %h want 00ad00ef", pio_out4[64 +: 32]); end
    n_cmp++; if (pio_out4[32 +: 32] !== 32'h0000_00A5) begin n_err++; $display("FAIL be_other_ch: got %h want 000000a5", pio_out4[32 +: 32]); end
    rd4(4'd9, d, v);
    n_cmp++; if (v !== 1'b1 || d !== 32'h00AD_00EF) begin n_err++; $display("FAIL be_readback: got v=%b d=%h want v=1 d=00ad00ef", v, d); end
    @(negedge clk);
    n_cmp++; if (bus4.avs_readdatavalid !== 1'b0) begin n_err++; $display("FAIL rdv_single_cycle: got %b want 0", bus4.avs_readdatavalid); end
    n_cmp++; if (bus4.avs_readdata !== 32'h00AD_00EF) begin n_err++; $display("FAIL rdata_hold: got %h want 00ad00ef", bus4.avs_readdata); end
    // Same-cycle read and write: read sees the old value.
    bus4.avs_address = 4'd9; bus4.avs_writedata = 32'h1111_2222; bus4.avs_byteenable = 4'hF;
    bus4.avs_read = 1'b1; bus4.avs_write = 1'b1;
    @(negedge clk);
    bus4.avs_read = 1'b0; bus4.avs_write = 1'b0;
    n_cmp++; if (bus4.avs_readdata !== 32'h00AD_00EF) begin n_err++; $display("FAIL rw_same_cycle_read: got %h want 00ad00ef", bus4.avs_readdata); end
    n_cmp++; if (pio_out4[64 +: 32] !== 32'h1111_2222) begin n_err++; $display("FAIL rw_same_cycle_write: got %h want 11112222", pio_out4[64 +: 32]); end
  endtask

  task automatic test_edge_irq();
    logic [31:0] d; logic v;
    wr4(4'd6, 32'h1, 4'hF);
    pio_in4[32] = 1'b1;
    repeat (2) @(negedge clk);
    n_cmp++; if (irq4 !== 1'b0) begin n_err++; $display("FAIL edge_irq_early: got %b want 0", irq4); end
    rd4(4'd7, d, v);
    n_cmp++; if (v !== 1'b1 || d !== 32'h0) begin n_err++; $display("FAIL edge_cap_not_yet: got v=%b d=%h want v=1 d=0", v, d); end
    n_cmp++; if (irq4 !== 1'b0) begin n_err++; $display("FAIL edge_irq_cycle3: got %b want 0", irq4); end
    rd4(4'd7, d, v);
    n_cmp++; if (v !== 1'b1 || d !== 32'h1) begin n_err++; $display("FAIL edge_cap_set: got v=%b d=%h want v=1 d=1", v, d); end
    n_cmp++; if (irq4 !== 1'b1) begin n_err++; $display("FAIL edge_irq_rise: got %b want 1", irq4); end
    wr4(4'd7, 32'h1, 4'hF);
    n_cmp++; if (irq4 !== 1'b1) begin n_err++; $display("FAIL clr_irq_still_high: got %b want 1", irq4); end
    @(negedge clk);
    n_cmp++; if (irq4 !== 1'b0) begin n_err++; $display("FAIL clr_irq_fall: got %b want 0", irq4); end
    pio_in4[32] = 1'b0;
    repeat (4) @(negedge clk);
    rd4(4'd7, d, v);
    n_cmp++; if (d !== 32'h0 || irq4 !== 1'b0) begin n_err++; $display("FAIL falling_ignored: got cap=%h irq=%b want cap=0 irq=0", d, irq4); end
  endtask

  task automatic test_set_wins();
    logic [31:0] d; logic v;
    wr4(4'd2, 32'h8, 4'hF);
    pio_in4[3] = 1'b1;
    repeat (4) @(negedge clk);
    n_cmp++; if (irq4 !== 1'b1) begin n_err++; $display("FAIL sw_irq_first: got %b want 1", irq4); end
    pio_in4[3] = 1'b0;
    repeat (4) @(negedge clk);
    rd4(4'd3, d, v);
    n_cmp++; if (d !== 32'h8 || irq4 !== 1'b1) begin n_err++; $display("FAIL sw_sticky: got cap=%h irq=%b want cap=8 irq=1", d, irq4); end
    pio_in4[3] = 1'b1;
    repeat (2) @(negedge clk);
    wr4(4'd3, 32'h8, 4'hF);
    @(negedge clk);
    n_cmp++; if (irq4 !== 1'b1) begin n_err++; $display("FAIL sw_irq_kept: got %b want 1", irq4); end
    rd4(4'd3, d, v);
    n_cmp++; if (d !== 32'h8) begin n_err++; $display("FAIL sw_set_wins: got %h want 00000008", d); end
    wr4(4'd3, 32'hFFFF_FFF7, 4'hF);
    rd4(4'd3, d, v);
    n_cmp++; if (d !== 32'h8) begin n_err++; $display("FAIL sw_clear_zero_bits: got %h want 00000008", d); end
    wr4(4'd3, 32'h8, 4'hF);
    rd4(4'd3, d, v);
    n_cmp++; if (d !== 32'h0 || irq4 !== 1'b0) begin n_err++; $display("FAIL sw_final_clear: got cap=%h irq=%b want cap=0 irq=0", d, irq4); end
  endtask

  task automatic test_out_of_range();
    logic [31:0] d; logic v;
    wr3(4'd9, 32'h1234_5678, 4'hF);
    rd3(4'd9, d, v);
    n_cmp++; if (v !== 1'b1 || d !== 32'h1234_5678) begin n_err++; $display("FAIL oor_setup_read: got v=%b d=%h want v=1 d=12345678", v, d); end
    rd3(4'd13, d, v);
    n_cmp++; if (v !== 1'b1 || d !== 32'h0) begin n_err++; $display("FAIL oor_read: got v=%b d=%h want v=1 d=0", v, d); end
    wr3(4'd13, 32'hFFFF_FFFF, 4'hF);
    wr3(4'd14, 32'hFFFF_FFFF, 4'hF);
    wr3(4'd15, 32'hFFFF_FFFF, 4'hF);
    n_cmp++; if (pio_out3 !== {32'h1234_5678, 64'h0}) begin n_err++; $display("FAIL oor_write_pio_out: got %h want 12345678 followed by zeros", pio_out3); end
    rd3(4'd10, d, v);
    n_cmp++; if (d !== 32'h0) begin n_err++; $display("FAIL oor_mask_ch2: got %h want 0", d); end
    rd3(4'd2, d, v);
    n_cmp++; if (d !== 32'h0) begin n_err++; $display("FAIL oor_mask_ch0: got %h want 0", d); end
    n_cmp++; if (irq3 !== 1'b0) begin n_err++; $display("FAIL oor_irq: got %b want 0", irq3); end
  endtask

  task automatic test_debounce();
    logic [31:0] d; logic v;
    wr4(4'd2, 32'h1, 4'hF);
    for (int i = 0; i < 20; i++) begin
      pio_in4[0] = ~pio_in4[0];
      repeat (5) @(negedge clk);
    end
    rd4(4'd0, d, v);
    n_cmp++; if (d !== 32'h0) begin n_err++; $display("FAIL db_bounce_data_in: got %h want 0", d); end
    rd4(4'd3, d, v);
    n_cmp++; if (d !== 32'h0 || irq4 !== 1'b0) begin n_err++; $display("FAIL db_bounce_cap: got cap=%h irq=%b want 0 0", d, irq4); end
    pio_in4[0] = 1'b1;
    repeat (18) @(negedge clk);
    rd4(4'd0, d, v);
    n_cmp++; if (d !== 32'h0) begin n_err++; $display("FAIL db_data_in_early: got %h want 0", d); end
    rd4(4'd3, d, v);
    n_cmp++; if (d !== 32'h0 || irq4 !== 1'b0) begin n_err++; $display("FAIL db_cap_early: got cap=%h irq=%b want 0 0", d, irq4); end
    rd4(4'd0, d, v);
    n_cmp++; if (d !== 32'h1) begin n_err++; $display("FAIL db_data_in_19: got %h want 1", d); end
    n_cmp++; if (irq4 !== 1'b1) begin n_err++; $display("FAIL db_irq: got %b want 1", irq4); end
    rd4(4'd3, d, v);
    n_cmp++; if (d !== 32'h1) begin n_err++; $display("FAIL db_cap_set: got %h want 1", d); end
  endtask

  initial begin
    reset = 1'b1;
    pio_in4 = '0; pio_in3 = '0;
    bus4.avs_address = '0; bus4.avs_read = 1'b0; bus4.avs_write = 1'b0;
    bus4.avs_writedata = '0; bus4.avs_byteenable = '0;
    bus3.avs_address = '0; bus3.avs_read = 1'b0; bus3.avs_write = 1'b0;
    bus3.avs_writedata = '0; bus3.avs_byteenable = '0;
    @(negedge clk);
    test_reset();
    test_byte_write();
    test_out_of_range();
`ifdef PIO_BANK_DEBOUNCE_EN
    test_debounce();
`else
    test_edge_irq();
    test_set_wins();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/pio_bank.md
Name: pio_bank

Overview:
Parametrised multi-channel parallel I/O block on the PCIe-bridged Avalon-MM bus. It replaces the separate per-function 32-bit PIOs (buttons, switches, LEDs, displays, hex port) with one addressable bank of NUM_CH channels. Each channel has:
- a synchronised input port
- a registered output port
- sticky edge capture
- a per-bit interrupt mask

All channels are combined into one interrupt line to the PCIe hard IP.

Parameters:
NUM_CH, 4, number of I/O channels (1..16)
WIDTH, 32, bits per channel (1..32); register bits [31:WIDTH] read 0, writes ignored
EDGE_MODE, 0, edge that sets capture bits: 0 rising, 1 falling, 2 any
OUT_RESET, 0, reset value of every channel output register
DEBOUNCE_CYCLES, 16, stable cycles required by input filter (used only with PIO_BANK_DEBOUNCE_EN)

Ports:
clk  input  1  system clock
reset  input  1  synchronous reset, active-high
avs_address  input  clog2(NUM_CH)+2  word address: channel = addr[MSB:2], register = addr[1:0]
avs_read  input  1  read strobe
avs_write  input  1  write strobe
avs_writedata  input  32  write data
avs_byteenable  input  4  byte lanes for writes
avs_readdata  output  32  read data, registered
avs_readdatavalid  output  1  high one cycle when avs_readdata is valid
pio_in  input  NUM_CH*WIDTH  external inputs, channel c at [c*WIDTH +: WIDTH], asynchronous to clk
pio_out  output  NUM_CH*WIDTH  external outputs, same packing
irq  output  1  level interrupt, registered

Behaviour:
- Clock and reset: single clock clk. Reset is synchronous, active-high, sampled on the rising edge of clk.
- Values on reset:
  - pio_out = OUT_RESET in every channel
  - avs_readdata = 0, avs_readdatavalid = 0, irq = 0
  - all mask, capture, synchroniser and edge-history flops = 0
- Reset mid-transaction: a read or write issued in the same cycle as reset is dropped, and no readdatavalid follows.
- Register map, per channel (word offsets):
  - 0 DATA_IN: RO, synchronised/filtered input
  - 1 DATA_OUT: RW
  - 2 IRQ_MASK: RW
  - 3 EDGE_CAP: read returns sticky bits; write-1-to-clear
- Input path: 2-flop synchroniser per bit, then the optional filter, then the edge detector against a 1-cycle-delayed copy.
  - Input-to-DATA_IN latency: 2 cycles (filter off).
  - Input-to-capture-bit latency: 3 cycles.
- Edge capture: a bit sets on the selected edge. A W1C clear and a new edge on the same bit in the same cycle: set wins. Clearing 0-bits has no effect.
- Writes:
  - take effect on the clock edge where avs_write = 1
  - byteenable lane k gates bits [8k+7:8k]
  - pio_out reflects a DATA_OUT write 1 cycle after the write cycle
- Reads:
  - 1-cycle fixed latency: avs_readdatavalid = 1 the cycle after avs_read, with avs_readdata valid that cycle; otherwise avs_readdatavalid = 0
  - avs_readdata holds its last value when no read is in progress
  - back-to-back reads supported, one per cycle
  - read and write to the same register in the same cycle: the read returns the pre-write value
  - simultaneous avs_read and avs_write both execute
- Out-of-range channel (address channel index >= NUM_CH): read returns 0 with readdatavalid; write ignored.
- irq = registered OR over all channels of (EDGE_CAP & IRQ_MASK). It rises 1 cycle after the capture bit sets with its mask set. It falls 1 cycle after the last contributing bit is cleared or masked.
- No waitrequest: the slave always accepts.

Optional Feature:
- Macro: PIO_BANK_DEBOUNCE_EN.
- When defined:
  - Each channel gets a stability counter of width clog2(DEBOUNCE_CYCLES+1) and a filtered register.
  - The counter resets to 0 whenever the synchronised channel value differs from its previous-cycle value. Otherwise it increments, saturating at DEBOUNCE_CYCLES.
  - The filtered register loads the synchronised value on the cycle the counter reaches DEBOUNCE_CYCLES.
  - DATA_IN and edge detection use the filtered value. Latency becomes 2 + DEBOUNCE_CYCLES + 1 cycles from a stable change.
  - Filter state resets to 0.
- When not defined: the filter is absent, the synchronised value feeds DATA_IN directly, and no counter logic is generated.

Test Plan:
- Reset values: assert reset 3 cycles with OUT_RESET=32'h0000_00A5, NUM_CH=4 -> every pio_out channel = 0xA5, irq=0; reads of DATA_IN, IRQ_MASK and EDGE_CAP on all channels return 0 (pio_in held 0).
- Byte-enabled write: write 0xDEADBEEF, byteenable=4'b0101, to ch2 DATA_OUT (addr 9) -> pio_out ch2 = 0x00AD00EF one cycle later; readback of addr 9 returns 0x00AD00EF with readdatavalid exactly 1 cycle after the read.
- Edge capture and irq (EDGE_MODE=0):
  - write IRQ_MASK ch1 = 0x1, then drive pio_in ch1 bit0 0->1 -> EDGE_CAP ch1 = 0x1 after 3 cycles and irq=1 the next cycle
  - write 0x1 to EDGE_CAP ch1 -> irq=0 the cycle after the write
- Simultaneous clear and new edge: time a W1C of bit3 on ch0 to coincide with a new rising edge on bit3 -> bit3 remains 1 and irq stays asserted.
- Out-of-range channel: NUM_CH=3, read addr 13 -> readdata 0 with readdatavalid; write to addr 13 -> no channel register changes.
- Debounce (PIO_BANK_DEBOUNCE_EN, DEBOUNCE_CYCLES=16):
  - toggle ch0 bit0 every 5 cycles for 100 cycles -> DATA_IN stays 0 and no capture
  - then hold bit0 at 1 -> DATA_IN = 1 exactly 19 cycles after the final change, and the capture bit sets one cycle later
